sum_accum: RTL and testbench

//  - Downstream stage of the registered 8-bit adder. Consumes its sum stream over a valid/ready handshake.
//  - Accumulates COUNT consecutive accepted sums into one frame result.
//  - Presents each result on a held valid/ready output, plus an overflow flag and a frame counter.

---
 rtl/sum_accum_pkg.sv | 15 +
 rtl/sum_accum_add.sv | 27 ++
 rtl/sum_accum.sv | 122 ++++++++++++
 tb/tb_sum_accum.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_accum_pkg.sv
// Shared types and default sizing for the sum_accum frame accumulator.
// Optional macro SUM_ACCUM_SAT_EN selects saturating arithmetic in sum_accum_add.
package sum_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned SUM_ACCUM_DATA_W = 8;
  localparam int unsigned SUM_ACCUM_ACC_W  = 10;
  localparam int unsigned SUM_ACCUM_COUNT  = 4;

endpackage

// File: rtl/sum_accum_add.sv
// Combinational accumulate step: acc + zero-extended in_data with carry-out.
// Macro SUM_ACCUM_SAT_EN: defined clamps to all-ones on carry, undefined wraps.
module sum_accum_add
  import sum_accum_pkg::*;
#(
  parameter int unsigned DATA_W = SUM_ACCUM_DATA_W,
  parameter int unsigned ACC_W  = SUM_ACCUM_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] in_data,
  output logic [ACC_W-1:0]  next_acc,
  output logic              carry
);

  logic [ACC_W:0] sum;

  assign sum   = {1'b0, acc} + (ACC_W+1)'(in_data);
  assign carry = sum[ACC_W];

`ifdef SUM_ACCUM_SAT_EN
  // Once clamped, adding any non-zero sample carries again, so the value sticks.
  assign next_acc = carry ? '1 : sum[ACC_W-1:0];
`else
  assign next_acc = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accum.sv
// Frame accumulator: sums COUNT accepted samples and holds the result until taken.
// Overflow arithmetic is selected in sum_accum_add by macro SUM_ACCUM_SAT_EN.
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int unsigned DATA_W = SUM_ACCUM_DATA_W,
  parameter int unsigned ACC_W  = SUM_ACCUM_ACC_W,
  parameter int unsigned COUNT  = SUM_ACCUM_COUNT,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic [7:0]        frames
);

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;
  logic [7:0]        frames_q, frames_d;

  logic              accept;
  logic              last;
  logic              carry;
  logic [ACC_W-1:0]  add_base;
  logic [ACC_W-1:0]  add_sum;

  assign in_ready = rst_n & ~clr & (state_q != HOLD);
  assign accept   = in_valid & in_ready;
  // A new frame starts from zero regardless of the stale accumulator.
  assign add_base = (state_q == IDLE) ? '0 : acc_q;
  assign last     = ((cnt_q + CNT_W'(1)) == CNT_W'(COUNT));

  sum_accum_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc      (add_base),
    .in_data  (in_data),
    .next_acc (add_sum),
    .carry    (carry)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    frames_d   = frames_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_d = add_sum;
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ((state_q == ACCUM) & ovf_q) | carry;
            if (last) begin
              state_d    = HOLD;
              out_data_d = add_sum;
              out_ovf_d  = ovf_d;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d  = IDLE;
            acc_d    = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            frames_d = frames_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      frames_q   <= frames_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign frames    = frames_q;

endmodule

// File: tb/tb_sum_accum.sv
// Bench for sum_accum: three configurations share one stimulus stream, each with a
// frame-level scoreboard; honours SUM_ACCUM_SAT_EN in its reference model.
module tb_sum_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instance 0: defaults. Instance 1: 9-bit accumulator. Instance 2: one sample per frame.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned AW = (g == 1) ? 9 : 10;
    localparam int unsigned CN = (g == 2) ? 1 : 4;
    localparam int unsigned CW = (g == 2) ? 1 : 3;

    logic          in_ready;
    logic          out_valid;
    logic [AW-1:0] out_data;
    logic          out_ovf;
    logic [7:0]    frames;

    sum_accum #(
      .DATA_W (8),
      .ACC_W  (AW),
      .COUNT  (CN),
      .CNT_W  (CW)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .frames    (frames)
    );

    int exp_q[$];
    int ovf_q[$];
    int part_sum   = 0;
    int part_n     = 0;
    int frames_exp = 0;

    // Check the current cycle against the model, then advance the model by the
    // events that the coming rising edge will commit.
    always @(negedge clk) begin
      int mx;
      int res;
      bit holding;
      mx      = (1 << AW) - 1;
      holding = (exp_q.size() != 0);
      if (!rst_n) begin
        check($sformatf("u%0d rst out_valid", g), int'(out_valid), 0);
        check($sformatf("u%0d rst in_ready", g), int'(in_ready), 0);
        check($sformatf("u%0d rst frames", g), int'(frames), 0);
        check($sformatf("u%0d rst out_data", g), int'(out_data), 0);
        check($sformatf("u%0d rst out_ovf", g), int'(out_ovf), 0);
        exp_q.delete();
        ovf_q.delete();
        part_sum   = 0;
        part_n     = 0;
        frames_exp = 0;
      end else begin
        check($sformatf("u%0d out_valid", g), int'(out_valid), int'(holding));
        check($sformatf("u%0d in_ready", g), int'(in_ready), int'(!holding && !clr));
        check($sformatf("u%0d frames", g), int'(frames), frames_exp);
        if (holding) begin
          check($sformatf("u%0d out_data", g), int'(out_data), exp_q[0]);
          check($sformatf("u%0d out_ovf", g), int'(out_ovf), ovf_q[0]);
        end
        if (clr) begin
          exp_q.delete();
          ovf_q.delete();
          part_sum = 0;
          part_n   = 0;
        end else if (holding) begin
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(ovf_q.pop_front());
            frames_exp = (frames_exp + 1) % 256;
          end
        end else if (in_valid) begin
          part_sum += int'(in_data);
          part_n++;
          if (part_n == CN) begin
`ifdef SUM_ACCUM_SAT_EN
            res = (part_sum > mx) ? mx : part_sum;
`else
            res = part_sum % (mx + 1);
`endif
            exp_q.push_back(res);
            ovf_q.push_back((part_sum > mx) ? 1 : 0);
            part_sum = 0;
            part_n   = 0;
          end
        end
      end
    end
  end

  task automatic send(input int d);
    in_valid = 1'b1;
    in_data  = 8'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("async out_valid", int'(g_dut[0].out_valid), 0);
    check("async in_ready", int'(g_dut[0].in_ready), 0);
    check("async out_data", int'(g_dut[0].out_data), 0);
    check("async frames", int'(g_dut[0].frames), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int sat_exp;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // 1: basic frame, result visible the cycle after the fourth accept
    send(10); send(20); send(30); send(40);
    in_valid = 1'b0;
    check("t1 out_valid", int'(g_dut[0].out_valid), 1);
    check("t1 out_data", int'(g_dut[0].out_data), 100);
    check("t1 out_ovf", int'(g_dut[0].out_ovf), 0);
    idle(1);
    check("t1 frames", int'(g_dut[0].frames), 1);
    check("t1 valid drop", int'(g_dut[0].out_valid), 0);

    // 2: backpressure holds the result and blocks input
    out_ready = 1'b0;
    send(255); send(255); send(255); send(255);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      check("t2 out_data", int'(g_dut[0].out_data), 1020);
      check("t2 in_ready", int'(g_dut[0].in_ready), 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(1);
    check("t2 frames", int'(g_dut[0].frames), 2);
    idle(1);

    // 3: overflow on the 9-bit instance
    send(200); send(200); send(200); send(200);
    in_valid = 1'b0;
`ifdef SUM_ACCUM_SAT_EN
    sat_exp = 511;
`else
    sat_exp = 288;
`endif
    check("t3 out_valid", int'(g_dut[1].out_valid), 1);
    check("t3 out_data", int'(g_dut[1].out_data), sat_exp);
    check("t3 out_ovf", int'(g_dut[1].out_ovf), 1);
    idle(2);

    // 4: clr aborts a partial frame and blocks the sample offered with it
    send(5); send(6);
    clr = 1'b1;
    send(9);
    clr = 1'b0;
    send(1); send(1); send(1); send(1);
    in_valid = 1'b0;
    check("t4 out_data", int'(g_dut[0].out_data), 4);
    idle(1);
    check("t4 frames", int'(g_dut[0].frames), 4);
    idle(1);

    // 5: async reset mid-accumulate and mid-hold
    send(1); send(2);
    in_valid = 1'b0;
    async_reset();
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    in_valid = 1'b0;
    check("t5 hold valid", int'(g_dut[0].out_valid), 1);
    async_reset();
    out_ready = 1'b1;
    idle(1);
    send(1); send(2); send(3); send(4);
    in_valid = 1'b0;
    check("t5 out_data", int'(g_dut[0].out_data), 10);
    idle(1);
    check("t5 frames", int'(g_dut[0].frames), 1);
    idle(2);

    // 6: single-sample frames alternate accept and handover
    for (int v = 7; v <= 9; v++) begin
      in_valid = 1'b1;
      in_data  = 8'(v);
      check("t6 ready hi", int'(g_dut[2].in_ready), 1);
      @(posedge clk);
      #1;
      check("t6 out_valid", int'(g_dut[2].out_valid), 1);
      check("t6 out_data", int'(g_dut[2].out_data), v);
      check("t6 ready lo", int'(g_dut[2].in_ready), 0);
      @(posedge clk);
      #1;
    end
    idle(2);

    // Random traffic with backpressure and occasional aborts
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 29) == 0);
      @(posedge clk);
      #1;
    end
    clr       = 1'b0;
    out_ready = 1'b1;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
